alu_bist_ctrl: RTL and testbench

Self-test sequencer for the 8-bit, 4-bit-opcode behavioral ALU. It drives opcode and operands into the ALU over a fixed 32-vector sweep and captures the ALU's x/y results into a 16-bit MISR signature. It reports pass/fail against a golden signature. It sits beside the ALU as the stimulus driver and result consumer, and replaces bench-only sweeps with an on-chip, synthesizable check.

---
 rtl/alu_bist_ctrl.sv | 144 ++++++++++++++
 tb/tb_alu_bist_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_bist_ctrl
// Purpose  : Sweeps 32 opcode/operand vectors into a combinational ALU and
//            compresses x/y results into a 16-bit MISR checked against golden.
// Revision : 1.0 - initial release
// ============================================================================
module alu_bist_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    input  logic [15:0]      golden,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_x,
    input  logic [WIDTH-1:0] alu_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      signature
);

    localparam int              c_CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_CW-1:0] c_SETTLE_LOAD = c_CW'(SETTLE - 1);
    localparam logic [4:0]      c_LAST_VEC    = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           r_state;
    logic [4:0]       r_idx;
    logic [c_CW-1:0]  r_settle;
    logic [WIDTH-1:0] r_seed_a;
    logic [WIDTH-1:0] r_seed_b;

    logic [2*WIDTH-1:0] w_xy;
    logic [15:0]        w_xy16;
    logic               w_fb;
    logic [15:0]        w_sig_next;
    logic [4:0]         w_idx_next;

    assign w_xy = {alu_x, alu_y};

    // Results wider than the signature keep their low 16 bits; narrower ones are zero-padded.
    generate
        if (2 * WIDTH >= 16) begin : g_fold_trunc
            assign w_xy16 = w_xy[15:0];
        end else begin : g_fold_pad
            assign w_xy16 = {{(16 - 2 * WIDTH){1'b0}}, w_xy};
        end
    endgenerate

    assign w_fb       = signature[15] ^ signature[14] ^ signature[12] ^ signature[3];
    assign w_sig_next = {signature[14:0], w_fb} ^ w_xy16;
    assign w_idx_next = r_idx + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= 5'd0;
            r_settle   <= '0;
            r_seed_a   <= '0;
            r_seed_b   <= '0;
            alu_opcode <= 4'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            signature  <= 16'h0000;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_seed_a   <= seed_a;
                        r_seed_b   <= seed_b;
                        signature  <= 16'hFFFF;
                        pass       <= 1'b0;
                        r_idx      <= 5'd0;
                        alu_opcode <= 4'd0;
                        alu_a      <= seed_a;
                        alu_b      <= seed_b;
                        r_settle   <= c_SETTLE_LOAD;
                        busy       <= 1'b1;
                        r_state    <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_settle == '0) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        signature <= w_sig_next;
                        if (r_idx == c_LAST_VEC) begin
                            // pass is resolved from the final signature so it is valid alongside done.
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (w_sig_next == golden);
                            r_state <= S_DONE;
                        end else begin
                            r_idx      <= w_idx_next;
                            alu_opcode <= w_idx_next[3:0];
                            alu_a      <= w_idx_next[4] ? {WIDTH{1'b1}} : r_seed_a;
                            alu_b      <= w_idx_next[4] ? {WIDTH{1'b0}} : r_seed_b;
                            r_settle   <= c_SETTLE_LOAD;
                            r_state    <= S_DRIVE;
                        end
                    end
                end
                S_DONE: begin
                    pass    <= abort ? 1'b0 : (signature == golden);
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_bist_ctrl.sv
`default_nettype none
// Bench for alu_bist_ctrl: a behavioral 8-bit ALU with fault modes, a vector
// scoreboard queue and an independent signature model.
module tb_alu_bist_ctrl;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic        abort  = 1'b0;
    logic [7:0]  seed_a = 8'h00;
    logic [7:0]  seed_b = 8'h00;
    logic [15:0] golden = 16'h0000;
    int          alu_mode = 0;

    logic [3:0]  alu_opcode, op3;
    logic [7:0]  alu_a, alu_b, alu_x, alu_y, a3, b3, x3, y3;
    logic        busy, done, pass, busy3, done3, pass3;
    logic [15:0] signature, sig3;

    int checks   = 0;
    int failures = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    alu_bist_ctrl #(.WIDTH(8), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .seed_a(seed_a), .seed_b(seed_b), .golden(golden),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_x(alu_x), .alu_y(alu_y),
        .busy(busy), .done(done), .pass(pass), .signature(signature)
    );

    alu_bist_ctrl #(.WIDTH(8), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .seed_a(seed_a), .seed_b(seed_b), .golden(golden),
        .alu_opcode(op3), .alu_a(a3), .alu_b(b3),
        .alu_x(x3), .alu_y(y3),
        .busy(busy3), .done(done3), .pass(pass3), .signature(sig3)
    );

    // mode 0: real ALU, 1: stub x=y=0, 2: stub with x[0] stuck-at-1 on opcode 6
    function automatic logic [15:0] alu_fn(input int mode, input logic [3:0] op,
                                           input logic [7:0] a, input logic [7:0] b);
        logic [7:0]  x, y;
        logic [8:0]  t;
        logic [15:0] p;
        x = 8'h00; y = 8'h00; t = 9'h000; p = 16'h0000;
        case (op)
            4'd0:  begin t = {1'b0, a} + {1'b0, b}; x = t[7:0]; y = {7'd0, t[8]}; end
            4'd1:  begin t = {1'b0, a} - {1'b0, b}; x = t[7:0]; y = {7'd0, t[8]}; end
            4'd2:  begin x = a & b; y = a | b; end
            4'd3:  begin x = a | b; y = a ^ b; end
            4'd4:  begin x = a ^ b; y = ~a; end
            4'd5:  begin x = ~a; y = ~b; end
            4'd6:  begin x = a << 1; y = a >> 1; end
            4'd7:  begin x = a >> 1; y = b << 1; end
            4'd8:  begin p = {8'd0, a} * {8'd0, b}; x = p[7:0]; y = p[15:8]; end
            4'd9:  begin x = a + 8'd1; y = b - 8'd1; end
            4'd10: begin x = a - 8'd1; y = b + 8'd1; end
            4'd11: begin x = {a[6:0], a[7]}; y = {b[0], b[7:1]}; end
            4'd12: begin x = {a[3:0], a[7:4]}; y = b; end
            4'd13: begin x = {7'd0, (a < b)}; y = {7'd0, (a == b)}; end
            4'd14: begin x = (a > b) ? a : b; y = (a > b) ? b : a; end
            default: begin x = a; y = b; end
        endcase
        if (mode != 0) begin
            x = 8'h00; y = 8'h00;
            if (mode == 2 && op == 4'd6) x[0] = 1'b1;
        end
        return {x, y};
    endfunction

    always_comb {alu_x, alu_y} = alu_fn(alu_mode, alu_opcode, alu_a, alu_b);
    always_comb {x3, y3}       = alu_fn(alu_mode, op3, a3, b3);

    function automatic logic [15:0] model_sig(input logic [7:0] sa, input logic [7:0] sb,
                                              input int mode, input int n);
        logic [15:0] s, xy;
        logic [7:0]  a, b;
        logic [3:0]  op;
        logic        fb;
        s = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            op = k[3:0];
            a  = (k < 16) ? sa : 8'hFF;
            b  = (k < 16) ? sb : 8'h00;
            xy = alu_fn(mode, op, a, b);
            fb = s[15] ^ s[14] ^ s[12] ^ s[3];
            s  = {s[14:0], fb} ^ xy;
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sweep(input logic [7:0] sa, input logic [7:0] sb, input logic [15:0] gold,
                            input int mode, input bit repulse, output logic [15:0] sig_out);
        logic [15:0] exp_sig;
        logic        exp_pass;
        logic [19:0] e, v;
        int          dcnt, bcnt;
        exp_sig  = model_sig(sa, sb, mode, 32);
        exp_pass = (exp_sig == gold);
        alu_mode = mode; seed_a = sa; seed_b = sb; golden = gold;
        for (int k = 0; k < 32; k++)
            exp_q.push_back({k[3:0], (k < 16) ? sa : 8'hFF, (k < 16) ? sb : 8'h00});
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (signature !== 16'hFFFF) begin failures++; $display("FAIL sweep_init_sig got=%h exp=ffff", signature); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL sweep_init_pass got=%b exp=0", pass); end
        dcnt = 0; bcnt = 0; e = 20'h0;
        for (int c = 0; c < 64; c++) begin
            if (done !== 1'b0) dcnt++;
            if (busy !== 1'b1) bcnt++;
            if (c % 2 == 0) e = exp_q.pop_front();
            v = {alu_opcode, alu_a, alu_b};
            checks++; if (v !== e) begin failures++; $display("FAIL vector k=%0d cyc=%0d got=%h exp=%h", c / 2, c, v, e); end
            start = repulse && (c == 5 || c == 30);
            tick();
        end
        start = 1'b0;
        checks++; if (dcnt != 0) begin failures++; $display("FAIL early_done count got=%0d exp=0", dcnt); end
        checks++; if (bcnt != 0) begin failures++; $display("FAIL busy_low_in_sweep count got=%0d exp=0", bcnt); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL done_at_64 got=%b exp=1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_in_done got=%b exp=0", busy); end
        checks++; if (signature !== exp_sig) begin failures++; $display("FAIL signature got=%h exp=%h", signature, exp_sig); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_width got=%b exp=0", done); end
        checks++; if (pass !== exp_pass) begin failures++; $display("FAIL pass got=%b exp=%b", pass, exp_pass); end
        checks++; if (signature !== exp_sig) begin failures++; $display("FAIL signature_hold got=%h exp=%h", signature, exp_sig); end
        sig_out = signature;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (alu_opcode !== 4'd0) begin failures++; $display("FAIL reset_opcode got=%h exp=0", alu_opcode); end
        checks++; if (alu_a !== 8'h00 || alu_b !== 8'h00) begin failures++; $display("FAIL reset_ab got=%h/%h exp=00/00", alu_a, alu_b); end
        checks++; if ({busy, done, pass} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, pass}); end
        checks++; if (signature !== 16'h0000) begin failures++; $display("FAIL reset_sig got=%h exp=0000", signature); end
        rst_n = 1'b1;
        tick(); tick();
        checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL idle_after_reset got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_order();
        logic [15:0] got;
        do_sweep(8'h0A, 8'h05, model_sig(8'h0A, 8'h05, 0, 32), 0, 1'b0, got);
    endtask

    task automatic test_back_to_back();
        logic [15:0] s, got;
        s = model_sig(8'h5C, 8'hA3, 0, 32);
        do_sweep(8'h5C, 8'hA3, s, 0, 1'b0, got);
        checks++; if (pass !== 1'b1) begin failures++; $display("FAIL golden_match got=%b exp=1", pass); end
        do_sweep(8'h5C, 8'hA3, s ^ 16'h0001, 0, 1'b0, got);
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL golden_off_by_one got=%b exp=0", pass); end
    endtask

    task automatic test_fault();
        logic [15:0] s0, got;
        s0 = model_sig(8'h0A, 8'h05, 1, 32);
        do_sweep(8'h0A, 8'h05, s0, 1, 1'b0, got);
        do_sweep(8'h0A, 8'h05, s0, 2, 1'b0, got);
        checks++; if (got === s0) begin failures++; $display("FAIL fault_detect got=%h exp!=%h", got, s0); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL fault_pass got=%b exp=0", pass); end
        alu_mode = 0;
    endtask

    task automatic test_abort();
        logic [15:0] part, got;
        part = model_sig(8'h33, 8'hC4, 0, 4);
        alu_mode = 0; seed_a = 8'h33; seed_b = 8'hC4; golden = model_sig(8'h33, 8'hC4, 0, 32);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if ({done, pass} !== 2'b00) begin failures++; $display("FAIL abort_done_pass got=%b exp=00", {done, pass}); end
        checks++; if (signature !== part) begin failures++; $display("FAIL abort_partial_sig got=%h exp=%h", signature, part); end
        do_sweep(8'h33, 8'hC4, golden, 0, 1'b0, got);
    endtask

    task automatic test_start_ignored();
        logic [15:0] got;
        do_sweep(8'h96, 8'h69, model_sig(8'h96, 8'h69, 0, 32), 0, 1'b1, got);
    endtask

    task automatic test_reset_mid();
        int bad;
        seed_a = 8'h0A; seed_b = 8'h05;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst_n = 1'b0;
        #2;
        checks++; if ({alu_opcode, alu_a, alu_b} !== 20'h0) begin failures++; $display("FAIL midreset_alu got=%h exp=00000", {alu_opcode, alu_a, alu_b}); end
        checks++; if ({busy, done, pass} !== 3'b000) begin failures++; $display("FAIL midreset_flags got=%b exp=000", {busy, done, pass}); end
        checks++; if (signature !== 16'h0000) begin failures++; $display("FAIL midreset_sig got=%h exp=0000", signature); end
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 80; c++) begin
            if (busy !== 1'b0 || done !== 1'b0 || busy3 !== 1'b0 || done3 !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL activity_after_reset count got=%0d exp=0", bad); end
    endtask

    task automatic test_settle3();
        logic [15:0] s;
        int n;
        s = model_sig(8'h21, 8'h7E, 0, 32);
        alu_mode = 0; seed_a = 8'h21; seed_b = 8'h7E; golden = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done3 !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++; if (n != 128) begin failures++; $display("FAIL settle3_done_cycle got=%0d exp=128", n); end
        checks++; if (sig3 !== s) begin failures++; $display("FAIL settle3_sig got=%h exp=%h", sig3, s); end
        checks++; if (busy3 !== 1'b0 || pass3 !== 1'b1) begin failures++; $display("FAIL settle3_busy_pass got=%b%b exp=01", busy3, pass3); end
        tick();
        checks++; if (done3 !== 1'b0) begin failures++; $display("FAIL settle3_done_width got=%b exp=0", done3); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_order();
        test_back_to_back();
        test_fault();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        test_settle3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
